// File: rtl/seq_divider.sv
// seq_divider: iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// One restoring step per clock, so a normal operation takes N+1 cycles from the
// accepting edge to the done pulse. Divide-by-zero and signed overflow finish
// in one cycle. Trial subtraction uses the adder form a + ~b + 1, where
// carry-out = 1 means no borrow.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-low reset
//   start  - request, sampled only while idle
//   op     - 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   a, b   - dividend, divisor
//   busy   - operation in progress; start is ignored
//   done   - one-cycle pulse, result valid
//   result - quotient or remainder, held until the next accepted operation
module seq_divider #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int unsigned CW = $clog2(N) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam logic [N-1:0]  One    = N'(1);
  localparam logic [N-1:0]  IntMin = {1'b1, {(N-1){1'b0}}};
  localparam logic [CW-1:0] LastStep = CW'(N - 1);
  localparam logic [CW-1:0] CntMax   = CW'(N);

  logic [1:0]    state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [N-1:0]  q_q, q_d;      // dividend shifts out, quotient shifts in
  logic [N:0]    r_q, r_d;      // partial remainder
  logic [N-1:0]  d_q, d_d;      // divisor magnitude
  logic          qsign_q, qsign_d;
  logic          rsign_q, rsign_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic [N-1:0]  result_q, result_d;

  // Input decode for the accepting cycle
  logic         signed_op;
  logic         a_neg, b_neg;
  logic [N-1:0] abs_a, abs_b;
  logic         div_zero, overflow;

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & a[N-1];
  assign b_neg     = signed_op & b[N-1];
  assign abs_a     = a_neg ? (~a + One) : a;
  assign abs_b     = b_neg ? (~b + One) : b;
  assign div_zero  = (b == '0);
  assign overflow  = signed_op && (a == IntMin) && (b == '1);

  // Restoring step: shifted remainder minus divisor, carry-out set when no borrow
  logic [N:0]   r_shift;
  logic [N+1:0] trial_sum;
  logic         no_borrow;

  assign r_shift   = {r_q[N-1:0], q_q[N-1]};
  assign trial_sum = {1'b0, r_shift} + {1'b0, ~{1'b0, d_q}} + (N+2)'(1);
  assign no_borrow = trial_sum[N+1];

  // Final selection and sign correction; signs are latched as 0 for unsigned ops
  logic [N-1:0] fix_val;
  logic         fix_neg;
  logic [N-1:0] fix_out;

  assign fix_val = op_q[1] ? r_q[N-1:0] : q_q;
  assign fix_neg = ~op_q[0] & (op_q[1] ? rsign_q : qsign_q);
  assign fix_out = fix_neg ? (~fix_val + One) : fix_val;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    q_d      = q_q;
    r_d      = r_q;
    d_d      = d_q;
    qsign_d  = qsign_q;
    rsign_d  = rsign_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (div_zero) begin
            result_d = op[1] ? a : '1;
            done_d   = 1'b1;
          end else if (overflow) begin
            result_d = op[1] ? '0 : IntMin;
            done_d   = 1'b1;
          end else begin
            op_d    = op;
            q_d     = abs_a;
            d_d     = abs_b;
            r_d     = '0;
            qsign_d = signed_op & (a[N-1] ^ b[N-1]);
            rsign_d = signed_op & a[N-1];
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        r_d   = no_borrow ? trial_sum[N:0] : r_shift;
        q_d   = {q_q[N-2:0], no_borrow};
        cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CW'(1);
        if (cnt_q == LastStep) begin
          state_d = FIX;
        end
      end
      FIX: begin
        result_d = fix_out;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      q_q      <= '0;
      r_q      <= '0;
      d_q      <= '0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      q_q      <= q_d;
      r_q      <= r_d;
      d_q      <= d_d;
      qsign_q  <= qsign_d;
      rsign_q  <= rsign_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider. Expected results come from a reference
// model using native signed/unsigned division with the RISC-V special cases.
// Latency is measured as the number of clock edges after the start-sampling
// edge E0 at which done is first seen: 0 for special cases, N+1 otherwise.
module tb_seq_divider;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [N-1:0]  a = '0;
  logic [N-1:0]  b = '0;
  logic          busy;
  logic          done;
  logic [N-1:0]  result;

  int checks = 0;
  int errors = 0;

  seq_divider #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    logic ovf;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      2'b00:   model = (y == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 :
                       32'($signed(x) / $signed(y));
      2'b01:   model = (y == 0) ? 32'hFFFF_FFFF : x / y;
      2'b10:   model = (y == 0) ? x : ovf ? 32'h0 : 32'($signed(x) % $signed(y));
      default: model = (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int model_edges(input logic [1:0] o, input logic [31:0] x,
                                     input logic [31:0] y);
    if (y == 0) return 0;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 0;
    return N + 1;
  endfunction

  // Issue one operation and wait for done. Returns in the done cycle (#1 after the edge).
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int edges, output logic [31:0] res, output int busy_cycles,
                       output logic busy_at_done);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
    edges = 0;
    busy_cycles = 0;
    while (!done && edges < 100) begin
      if (busy) busy_cycles++;
      @(posedge clk); #1;
      edges++;
    end
    if (!done) edges = -1;
    res = result;
    busy_at_done = busy;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++;
    if (result !== '0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Table-driven directed cases; each checks result, latency, busy profile and done width.
  task automatic run_table(input string name, input logic [1:0] ops[], input logic [31:0] xs[],
                           input logic [31:0] ys[], input logic [31:0] exp[]);
    int e, bc, ee;
    logic [31:0] r;
    logic bd;
    for (int i = 0; i < ops.size(); i++) begin
      do_op(ops[i], xs[i], ys[i], e, r, bc, bd);
      ee = model_edges(ops[i], xs[i], ys[i]);
      checks++;
      if (r !== exp[i]) begin
        errors++; $display("FAIL %s_result[%0d] got %h want %h", name, i, r, exp[i]);
      end
      checks++;
      if (e != ee) begin
        errors++; $display("FAIL %s_latency[%0d] got %0d want %0d", name, i, e, ee);
      end
      checks++;
      if (bc != ((ee == 0) ? 0 : N + 1) || bd !== 1'b0) begin
        errors++;
        $display("FAIL %s_busy[%0d] got %0d/%b want %0d/0", name, i, bc, bd,
                 (ee == 0) ? 0 : N + 1);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || result !== exp[i]) begin
        errors++;
        $display("FAIL %s_after_done[%0d] got done=%b res=%h want done=0 res=%h", name, i,
                 done, result, exp[i]);
      end
    end
  endtask

  task automatic test_unsigned();
    run_table("unsigned", '{2'b01, 2'b11}, '{32'd100, 32'd100}, '{32'd7, 32'd7},
              '{32'd14, 32'd2});
  endtask

  task automatic test_signed();
    run_table("signed", '{2'b00, 2'b10, 2'b00},
              '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7}, '{32'd2, 32'd2, 32'hFFFF_FFFE},
              '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
  endtask

  task automatic test_div_zero();
    run_table("divzero", '{2'b01, 2'b11, 2'b00}, '{32'd5, 32'd5, 32'hFFFF_FFFF},
              '{32'd0, 32'd0, 32'd0}, '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF});
  endtask

  task automatic test_overflow();
    run_table("overflow", '{2'b00, 2'b10, 2'b01},
              '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000},
              '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
              '{32'h8000_0000, 32'h0, 32'h0});
  endtask

  task automatic test_ignore_start();
    int edges;
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd77; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    // 11 edges after E0 have now passed
    edges = 11;
    #1;
    while (!done && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    checks++;
    if (edges != N + 1) begin
      errors++; $display("FAIL ignore_latency got %0d want %0d", edges, N + 1);
    end
    checks++;
    if (result !== model(2'b01, 32'd1000, 32'd9)) begin
      errors++; $display("FAIL ignore_result got %h want %h", result,
                         model(2'b01, 32'd1000, 32'd9));
    end
    repeat (40) begin
      @(posedge clk); #1;
      if (done) begin
        checks++; errors++;
        $display("FAIL ignore_extra_done got 1 want 0");
      end
    end
  endtask

  task automatic test_back_to_back();
    int e1, e2, bc;
    logic [31:0] r1, r2;
    logic bd;
    do_op(2'b01, 32'd123456, 32'd321, e1, r1, bc, bd);
    // do_op returns in the done cycle, so the next start coincides with done
    do_op(2'b10, 32'hFFFF_0000, 32'd17, e2, r2, bc, bd);
    checks++;
    if (r1 !== model(2'b01, 32'd123456, 32'd321) || e1 != N + 1) begin
      errors++; $display("FAIL b2b_first got %h/%0d want %h/%0d", r1, e1,
                         model(2'b01, 32'd123456, 32'd321), N + 1);
    end
    checks++;
    if (r2 !== model(2'b10, 32'hFFFF_0000, 32'd17) || e2 != N + 1) begin
      errors++; $display("FAIL b2b_second got %h/%0d want %h/%0d", r2, e2,
                         model(2'b10, 32'hFFFF_0000, 32'd17), N + 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    int seen;
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd5000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL abort_state got busy=%b done=%b res=%h want 0/0/0", busy, done, result);
    end
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", seen); end
  endtask

  task automatic test_random();
    int e, bc, ee;
    logic [31:0] x, y, r, exp;
    logic [1:0] o;
    logic bd;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = 32'($urandom_range(1, 20));
        3: y = -32'($urandom_range(1, 20));
        4: x = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      do_op(o, x, y, e, r, bc, bd);
      exp = model(o, x, y);
      ee = model_edges(o, x, y);
      checks++;
      if (r !== exp || e != ee) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h got %h/%0d want %h/%0d", i, o, x, y,
                 r, e, exp, ee);
      end
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative RV32M divide/remainder unit for the Hunter_RV32 execute stage. It sits beside the 32-bit ripple-carry adder/subtractor and reuses the same subtract form each step: a + ~b + 1, with carry-out = 1 meaning no borrow. It implements DIV, DIVU, REM and REMU with a start/busy/done handshake. One restoring step runs per clock, so a normal operation takes N+1 cycles; RISC-V special cases finish in 1 cycle.

## Interface
- N, 32, operand/result width
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-low
- start  input  1  request; sampled only when not busy
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- a  input  N  dividend
- b  input  N  divisor
- busy  output  1  operation in progress; start ignored
- done  output  1  one-cycle pulse, result valid
- result  output  N  quotient or remainder; held until the next accepted start

## Operation
- States:
  - IDLE: accept start.
  - CALC: iterate.
  - FIX: sign-correct and write the result.
- IDLE, start=1, special case: write result directly, pulse done, stay in IDLE. Special cases are checked in this order:
  - b==0: quotient = all ones; remainder = a.
  - op==DIV or REM, a==0x80000000, b==0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- IDLE, start=1, otherwise:
  - Latch op.
  - Latch the magnitudes |a| and |b|. Use two's-complement absolute value for signed ops when the MSB is set; use raw operands for unsigned ops.
  - Latch quotient sign = a[N-1]^b[N-1] (signed ops only).
  - Latch remainder sign = a[N-1] (signed ops only).
  - Clear the partial remainder R (N+1 bits) and the step counter. Go to CALC.
- CALC, per cycle:
  - Shift {R, Q} left by 1, bringing in the next dividend MSB.
  - Trial = R_shifted − divisor, computed as add of the inverted divisor with carry-in 1.
  - No borrow: R = trial, Q LSB = 1. Borrow: keep R_shifted, Q LSB = 0.
  - After N steps, go to FIX.
- FIX:
  - Select Q (DIV/DIVU) or R[N-1:0] (REM/REMU).
  - Negate if the latched sign is set (signed ops only).
  - Register the value into result, pulse done, return to IDLE.
- Widths: arithmetic is N-bit two's complement. The magnitude of 0x80000000 is 0x80000000, treated as unsigned. Results wrap mod 2^N.
- The counter is ceil(log2(N))+1 bits wide and saturates at N. It must not wrap inside CALC.

## Timing
- Reset values: busy=0, done=0, result=0, state=IDLE.
- Reset asserted in any state aborts on the next edge. No done is produced for the aborted operation.
- Latency is counted from edge E0, the edge that samples start=1 in IDLE:
  - Special case: result valid and done=1 in the cycle after E0. busy stays 0.
  - Normal: busy=1 in the cycles after E0 through E0+N. result and done=1 in the cycle after E0+N+1, with busy=0 in that cycle. Total latency is N+1 cycles (33 for N=32).
- done is high for exactly one cycle per accepted operation.
- start is ignored while busy=1. The a, b and op inputs may change freely after E0.
- start=1 in the same cycle that done=1: accepted, since the unit is in IDLE. Back-to-back operations are therefore allowed.
- result is unchanged between done pulses.

## Test plan
- DIVU a=100, b=7 → done exactly 33 cycles after the start edge; result=14. Repeat with REMU → result=2.
- Signed: DIV a=−7 (0xFFFFFFF9), b=2 → 0xFFFFFFFD (−3). REM → 0xFFFFFFFF (−1). DIV a=7, b=−2 → 0xFFFFFFFD.
- Divide by zero: DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV −1/0 → 0xFFFFFFFF. All with done one cycle after start and busy never high.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0; latency 1. DIVU of the same operands → 0 (normal path, 33 cycles).
- Handshake:
  - Pulse start mid-CALC with different operands: ignored, and the original result is returned.
  - start coincident with done: second operation accepted, with its done 33 cycles later.
- Reset: assert rst=0 at cycle 10 of a DIVU → next cycle busy=0, done=0, result=0. No done pulse appears afterwards.
